// File: rtl/bresenham_pkg.sv
// ============================================================================
// Module : bresenham_pkg
// Brief  : Fixed-point constants, shared types and FSM encoding for the
//          Bresenham ray stepper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bresenham_pkg;

  localparam int          FRAC_BITS = 18;
  localparam logic [31:0] ONE       = 32'h0004_0000;
  localparam logic [31:0] HALF      = 32'h0002_0000;
  // pi in Q14.18 (3.14159265 * 2^18, rounded)
  localparam logic [31:0] PI        = 32'h000C_90FE;

  typedef logic signed [31:0] fixed_t;
  typedef logic signed [15:0] coord_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/octant_restore.sv
// ============================================================================
// Module : octant_restore
// Brief  : Maps first-octant (major, minor) step counts back to the real
//          octant: optional axis swap, then x negate, then y negate.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module octant_restore
  import bresenham_pkg::*;
#(
  parameter int COORD_W = 16
) (
  input  logic [COORD_W-1:0] i_major,
  input  logic [COORD_W-1:0] i_minor,
  input  logic               i_flip_identity,
  input  logic               i_flip_x,
  input  logic               i_flip_y,
  output logic [COORD_W-1:0] o_dx,
  output logic [COORD_W-1:0] o_dy
);

  logic [COORD_W-1:0] w_sx;
  logic [COORD_W-1:0] w_sy;

  always_comb begin
    w_sx = i_flip_identity ? i_minor : i_major;
    w_sy = i_flip_identity ? i_major : i_minor;
    o_dx = i_flip_x ? (-w_sx) : w_sx;
    o_dy = i_flip_y ? (-w_sy) : w_sy;
  end

endmodule

`default_nettype wire

// File: rtl/bresenham_stepper.sv
// ============================================================================
// Module : bresenham_stepper
// Brief  : Walks a grid ray one cell per cycle using a Q14.18 error term.
//          Optional map clipping under `BRESENHAM_BOUNDS_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bresenham_stepper
  import bresenham_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int LEN_W   = 16,
  parameter int MAP_W   = 1024,
  parameter int MAP_H   = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        slope,
  input  logic               flip_y,
  input  logic               flip_x,
  input  logic               flip_identity,
  input  logic [COORD_W-1:0] origin_x,
  input  logic [COORD_W-1:0] origin_y,
  input  logic [LEN_W-1:0]   length,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] cell_x,
  output logic [COORD_W-1:0] cell_y,
  output logic               out_last,
  output logic               clipped
);

  localparam logic [18:0] ERR_ONE  = ONE[18:0];
  localparam logic [18:0] ERR_HALF = HALF[18:0];

  state_t               r_state;
  state_t               w_state_nxt;
  logic [FRAC_BITS-1:0] r_slope;
  logic [18:0]          r_err;
  logic [LEN_W-1:0]     r_major;
  logic [LEN_W-1:0]     r_minor;
  logic [LEN_W-1:0]     r_len;
  logic [COORD_W-1:0]   r_org_x;
  logic [COORD_W-1:0]   r_org_y;
  logic                 r_flip_x;
  logic                 r_flip_y;
  logic                 r_flip_id;

  logic                 w_accept;
  logic                 w_fire;
  logic [FRAC_BITS-1:0] w_slope_clamp;
  logic [18:0]          w_err_sum;
  logic                 w_carry;
  logic [18:0]          w_err_nxt;
  logic [LEN_W-1:0]     w_major_nxt;
  logic [LEN_W-1:0]     w_minor_nxt;
  logic [COORD_W-1:0]   w_dx;
  logic [COORD_W-1:0]   w_dy;
  logic                 w_last_len;
  logic                 w_nxt_off;
  logic                 w_org_off;

  assign w_accept      = cmd_valid & cmd_ready;
  assign w_fire        = out_valid & out_ready;
  assign w_slope_clamp = (slope >= ONE) ? {FRAC_BITS{1'b1}} : slope[FRAC_BITS-1:0];

  // err stays below 1.0 after each step, so a 19-bit sum cannot overflow
  assign w_err_sum   = r_err + {1'b0, r_slope};
  assign w_carry     = (w_err_sum >= ERR_ONE);
  assign w_err_nxt   = w_carry ? (w_err_sum - ERR_ONE) : w_err_sum;
  assign w_major_nxt = r_major + 1'b1;
  assign w_minor_nxt = r_minor + {{(LEN_W-1){1'b0}}, w_carry};
  assign w_last_len  = (r_major == r_len);

  octant_restore #(.COORD_W(COORD_W)) u_cur (
    .i_major         (COORD_W'(r_major)),
    .i_minor         (COORD_W'(r_minor)),
    .i_flip_identity (r_flip_id),
    .i_flip_x        (r_flip_x),
    .i_flip_y        (r_flip_y),
    .o_dx            (w_dx),
    .o_dy            (w_dy)
  );

  assign cell_x = r_org_x + w_dx;
  assign cell_y = r_org_y + w_dy;

`ifdef BRESENHAM_BOUNDS_CHECK_EN
  logic [COORD_W-1:0] w_ndx;
  logic [COORD_W-1:0] w_ndy;
  logic               w_clip_evt;
  logic               r_clipped;

  function automatic logic in_map(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return !x[COORD_W-1] && (x < COORD_W'(MAP_W)) && !y[COORD_W-1] && (y < COORD_W'(MAP_H));
  endfunction

  // Look one step ahead so the edge cell can carry out_last itself
  octant_restore #(.COORD_W(COORD_W)) u_nxt (
    .i_major         (COORD_W'(w_major_nxt)),
    .i_minor         (COORD_W'(w_minor_nxt)),
    .i_flip_identity (r_flip_id),
    .i_flip_x        (r_flip_x),
    .i_flip_y        (r_flip_y),
    .o_dx            (w_ndx),
    .o_dy            (w_ndy)
  );

  assign w_nxt_off  = !in_map(r_org_x + w_ndx, r_org_y + w_ndy);
  assign w_org_off  = !in_map(origin_x, origin_y);
  assign w_clip_evt = (w_fire & w_nxt_off & ~w_last_len) | (w_accept & w_org_off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_clipped <= 1'b0;
    else        r_clipped <= w_clip_evt;
  end

  assign clipped = r_clipped;
`else
  assign w_nxt_off = 1'b0;
  assign w_org_off = 1'b0;
  assign clipped   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !w_org_off) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_fire && out_last)     w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == ST_IDLE);
    out_valid = (r_state == ST_RUN);
    out_last  = (r_state == ST_RUN) & (w_last_len | w_nxt_off);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slope   <= '0;
      r_err     <= '0;
      r_major   <= '0;
      r_minor   <= '0;
      r_len     <= '0;
      r_org_x   <= '0;
      r_org_y   <= '0;
      r_flip_x  <= 1'b0;
      r_flip_y  <= 1'b0;
      r_flip_id <= 1'b0;
    end else if (w_accept) begin
      r_slope   <= w_slope_clamp;
      r_err     <= ERR_HALF;
      r_major   <= '0;
      r_minor   <= '0;
      r_len     <= length;
      r_org_x   <= origin_x;
      r_org_y   <= origin_y;
      r_flip_x  <= flip_x;
      r_flip_y  <= flip_y;
      r_flip_id <= flip_identity;
    end else if (w_fire && !out_last) begin
      r_major <= w_major_nxt;
      r_minor <= w_minor_nxt;
      r_err   <= w_err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bresenham_stepper.sv
// ============================================================================
// Module : tb_bresenham_stepper
// Brief  : Directed vectors with a cell scoreboard for bresenham_stepper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bresenham_stepper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] slope;
  logic        flip_y, flip_x, flip_identity;
  logic [15:0] origin_x, origin_y;
  logic [15:0] length;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] cell_x, cell_y;
  logic        out_last;
  logic        clipped;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
  } cell_t;

  cell_t sbq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    clip_cnt = 0;
  bit    sb_en = 1'b1;
  bit    stall_prev = 1'b0;
  cell_t held;

  always #5 clk = ~clk;

  bresenham_stepper #(
    .COORD_W(16), .LEN_W(16), .MAP_W(64), .MAP_H(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .slope(slope), .flip_y(flip_y), .flip_x(flip_x), .flip_identity(flip_identity),
    .origin_x(origin_x), .origin_y(origin_y), .length(length),
    .out_valid(out_valid), .out_ready(out_ready),
    .cell_x(cell_x), .cell_y(cell_y), .out_last(out_last), .clipped(clipped)
  );

  // Monitor: pops the scoreboard on every accepted cell and checks stall hold
  always @(negedge clk) begin
    cell_t got;
    cell_t exp;
    got = {cell_x, cell_y, out_last};
    if (clipped) clip_cnt++;
    if (rst_n && stall_prev && out_valid) begin
      n_tests++;
      if (got !== held) begin
        n_fail++;
        $display("FAIL stall_hold: got x=%0d y=%0d last=%0b, held x=%0d y=%0d last=%0b",
                 $signed(got.x), $signed(got.y), got.last, $signed(held.x), $signed(held.y), held.last);
      end
    end
    stall_prev = rst_n && out_valid && !out_ready;
    held = got;
    if (rst_n && sb_en && out_valid && out_ready) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL cell: unexpected cell x=%0d y=%0d last=%0b, none expected",
                 $signed(got.x), $signed(got.y), got.last);
      end else begin
        exp = sbq.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL cell: got x=%0d y=%0d last=%0b, expected x=%0d y=%0d last=%0b",
                   $signed(got.x), $signed(got.y), got.last, $signed(exp.x), $signed(exp.y), exp.last);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input int x, input int y, input bit last);
    cell_t c;
    c.x = x[15:0];
    c.y = y[15:0];
    c.last = last;
    sbq.push_back(c);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL ray_timeout: %0d cells still expected after %0d cycles", sbq.size(), n);
      sbq.delete();
    end
  endtask

  task automatic issue(input logic [31:0] s, input bit fy, input bit fx, input bit fi,
                       input int ox, input int oy, input int len,
                       input bit stall, input bit wait_end);
    int n = 0;
    @(posedge clk);
    #1;
    slope = s; flip_y = fy; flip_x = fx; flip_identity = fi;
    origin_x = ox[15:0]; origin_y = oy[15:0]; length = len[15:0];
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_timeout: cmd_ready=%0b, expected 1", cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (stall) begin
      @(posedge clk);
      #1 out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    if (wait_end) wait_done();
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
    slope = '0; flip_y = 1'b0; flip_x = 1'b0; flip_identity = 1'b0;
    origin_x = '0; origin_y = '0; length = '0;

    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_clipped",   {31'd0, clipped},   32'd0);
    check("rst_cell", {cell_x, cell_y}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Half slope, no flags
    push(10, 20, 0); push(11, 21, 0); push(12, 21, 0); push(13, 22, 0); push(14, 22, 1);
    issue(32'h20000, 0, 0, 0, 10, 20, 4, 0, 1);

    // Same ray with every octant flag set
    push(10, 20, 0); push(9, 19, 0); push(9, 18, 0); push(8, 17, 0); push(8, 16, 1);
    issue(32'h20000, 1, 1, 1, 10, 20, 4, 0, 1);

    // Flat ray mirrored in x
    push(10, 20, 0); push(9, 20, 0); push(8, 20, 0); push(7, 20, 1);
    issue(32'h0, 0, 1, 0, 10, 20, 3, 0, 1);

    // Oversized slope clamps just below 1.0: pure diagonal
    push(0, 0, 0); push(1, 1, 0); push(2, 2, 0); push(3, 3, 1);
    issue(32'h50000, 0, 0, 0, 0, 0, 3, 0, 1);

    // Zero length emits only the origin
    push(5, 7, 1);
    issue(32'h20000, 0, 0, 0, 5, 7, 0, 0, 1);

    // Back-pressure on the second cell
    push(10, 20, 0); push(11, 21, 0); push(12, 21, 0); push(13, 22, 0); push(14, 22, 1);
    issue(32'h20000, 0, 0, 0, 10, 20, 4, 1, 1);

`ifndef BRESENHAM_BOUNDS_CHECK_EN
    // Coordinate wrap at the signed limit
    push(32767, 0, 0); push(-32768, 0, 1);
    issue(32'h0, 0, 0, 0, 32767, 0, 1, 0, 1);
`else
    begin
      int c0;
      c0 = clip_cnt;
      push(62, 5, 0); push(63, 5, 1);
      issue(32'h0, 0, 0, 0, 62, 5, 10, 0, 1);
      repeat (2) @(negedge clk);
      check("clip_pulses", clip_cnt - c0, 32'd1);
    end
`endif

    // Reset in the middle of a long ray
    sb_en = 1'b0;
    issue(32'h20000, 0, 0, 0, 10, 20, 20, 0, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_last",  {31'd0, out_last},  32'd0);
    check("midrst_cell", {cell_x, cell_y}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    sb_en = 1'b1;
    @(negedge clk);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    push(3, 4, 0); push(4, 5, 0); push(5, 5, 1);
    issue(32'h20000, 0, 0, 0, 3, 4, 2, 0, 1);

    repeat (2) @(negedge clk);
`ifndef BRESENHAM_BOUNDS_CHECK_EN
    check("clip_never", clip_cnt, 32'd0);
`endif
    check("sb_empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
